// File: rtl/moore_updown_counter.sv
// ---------------------------------------------------------------------------
// moore_updown_counter
//
// General-purpose modulo-MODULUS up/down counter for timers and event
// counters. All status outputs decode registered state only, so they are
// glitch-free and can drive downstream enables directly.
//
// Parameters
//   WIDTH    : counter width in bits (1..32)
//   MODULUS  : count range 0..MODULUS-1 (2..2**WIDTH)
//   SATURATE : 0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   x_in     : count enable
//   up_dn    : direction, 1 = increment, 0 = decrement
//   load     : synchronous parallel-load strobe (highest priority)
//   load_val : value taken on load, clamped to MODULUS-1
//   count    : current count
//   y_out    : high while count == MODULUS-1
//   zero     : high while count == 0
//   wrap     : one-cycle pulse in the cycle after a wrap/saturation event
// ---------------------------------------------------------------------------
module moore_updown_counter #(
  parameter int unsigned      WIDTH    = 4,
  parameter longint unsigned  MODULUS  = 16,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_in,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             y_out,
  output logic             zero,
  output logic             wrap
);

  // MODULUS is 64-bit so that MODULUS == 2**32 is representable; the
  // terminal value always fits in WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic [WIDTH-1:0] w_next_count;
  logic             w_next_wrap;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_count == MAX_VAL);
  assign w_at_zero = (r_count == '0);

  // Boundary tests are done before the +1/-1 so the adder never has to
  // produce a value outside 0..MODULUS-1, even when MODULUS == 2**WIDTH.
  always_comb begin
    w_next_count = r_count;
    w_next_wrap  = 1'b0;
    if (load) begin
      w_next_count = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (x_in) begin
      if (up_dn) begin
        if (w_at_max) begin
          w_next_count = SATURATE ? MAX_VAL : '0;
          w_next_wrap  = 1'b1;
        end else begin
          w_next_count = r_count + ONE;
        end
      end else begin
        if (w_at_zero) begin
          w_next_count = SATURATE ? '0 : MAX_VAL;
          w_next_wrap  = 1'b1;
        end else begin
          w_next_count = r_count - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_wrap  <= w_next_wrap;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign y_out = w_at_max;
  assign zero  = w_at_zero;

endmodule
